decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Superscalar successor to the single-instruction combinational decoder in the magic backend.
- Buffers up to FETCH_WIDTH fetched instructions per cycle in a circular queue of DEPTH entries.
- Presents up to DECODE_WIDTH oldest entries per cycle, each fully decoded: control word, sign-extended immediate, register indices, illegal flag.
- Sits between fetch and rename/dispatch; supports a pipeline flush.

Parameters:
- FETCH_WIDTH, 2, instructions offered by fetch per cycle.
- DECODE_WIDTH, 2, decoded instructions presented per cycle.
- DEPTH, 8, queue entries; power of 2; DEPTH >= max(FETCH_WIDTH, DECODE_WIDTH).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all queued entries.
- in_valid  in  FETCH_WIDTH  lane valids; must be a contiguous prefix from lane 0.
- in_instr  in  FETCH_WIDTH*32  instruction words, lane 0 oldest.
- in_pc  in  FETCH_WIDTH*32  PCs per lane.
- in_ready  out  1  queue can accept a full fetch group this cycle.
- out_valid  out  DECODE_WIDTH  slot k holds an entry; always a contiguous prefix.
- out_deq  in  $clog2(DECODE_WIDTH+1)  number of slots consumed this cycle, oldest first.
- out_ctrl  out  DECODE_WIDTH x control_word_t  decoded control word per slot (magic_backend_types).
- out_imm  out  DECODE_WIDTH*32  sign-extended immediate per slot.
- out_rs1, out_rs2, out_rd  out  DECODE_WIDTH*5 each  register indices.
- out_pc  out  DECODE_WIDTH*32  PC per slot.
- out_illegal  out  DECODE_WIDTH  unrecognised opcode.
- occupancy  out  $clog2(DEPTH+1)  registered entry count.

Behaviour:
- State: head pointer, tail pointer (each $clog2(DEPTH) bits, wrap modulo DEPTH), registered count, DEPTH entries of {instr, pc}.
- Reset and flush both clear head, tail and count to 0 on the next edge. Entry storage is not cleared.
- Outputs after reset: in_ready=1, out_valid=0, occupancy=0.
- in_ready = (DEPTH - count) >= FETCH_WIDTH.
  - Computed from the registered count only; a same-cycle dequeue does not raise in_ready.
- Push:
  - Occurs when in_ready && in_valid[0].
  - Writes the popcount(in_valid) lanes in order at tail, tail+1, … with wrap.
  - tail and count advance by the popcount.
- Pop:
  - out_valid[k] = (count > k).
  - out_deq > popcount(out_valid) is a protocol violation; the bench asserts on it.
  - head advances by out_deq; count decreases by out_deq.
- Simultaneous push and pop: count_next = count + pushed - out_deq. Both pointers move in the same cycle.
- Flush priority: flush overrides any same-cycle push and pop. rst overrides flush.
- Latency:
  - A pushed instruction appears on out_valid the cycle after acceptance.
  - There is no combinational in→out bypass, including when the queue is empty.
- Decode: combinational from the stored entries at head+k, with the same control word semantics as the single-instruction decoder.
  - lui: bypass, imm.
  - auipc: pc+imm.
  - jal, jalr: jump, write back PC.
  - branch: br_op = funct3.
  - load, store: mem_op = {store, funct3}.
  - op_imm: funct7 bit used only for funct3=5.
  - op_reg: alu_op = {funct7[5], funct3}.
- New decode rules:
  - rd_we forced to 0 when rd = x0.
  - Unknown opcode (including csr): out_illegal=1, rd_we=0, mem_op=none, br=0, jmp=0.
- Immediate formats, all sign-extended from instr[31]:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Slots with out_valid[k]=0 drive don't-care decode outputs. The bench checks them only when valid.

Optional Feature:
- Macro DECODE_RV32M_EN.
- Defined:
  - op_reg with funct7 = 7'b0000001 decodes as multiply/divide.
  - Sets ctrl.muldiv=1, muldiv_op=funct3, rd_we (subject to the x0 rule), out_illegal=0.
- Undefined:
  - The same encoding sets out_illegal=1 and rd_we=0.
  - ctrl.muldiv is tied 0.

Test Plan:
- Reset then push {0x00500093 addi x1,x0,5; 0x00000013 nop} at pc 0x1000/0x1004. Next cycle:
  - out_valid=2'b11, slot0 imm=5, rd=1, rd_we=1.
  - slot1 rd=0, rd_we=0.
  - occupancy=2.
- Fill with DEPTH=8 (4 groups of 2, no dequeue): in_ready=0 at count=8. A push attempted at that point is dropped and count stays 8.
- Wrap-around:
  - Dequeue 1 per cycle while pushing 2 per cycle until tail wraps past index 7.
  - Order of out_pc must remain strictly sequential, e.g. 0x1000, 0x1004, …
- Push and out_deq=2 in the same cycle at count=4 gives count=4 next cycle.
  - Asserting flush in that same cycle instead gives count=0 and out_valid=0.
- Decode check:
  - 0xFE000EE3 (beq, offset -4): imm=0xFFFFFFFC, br=1.
  - 0x800000B7 (lui x1): imm=0x80000000.
  - 0x0000007F: out_illegal=1.
- 0x022081B3 (mul x3,x1,x2):
  - With DECODE_RV32M_EN: muldiv=1, muldiv_op=0.
  - Without it: out_illegal=1, rd_we=0.

Source files
------------

// File: rtl/decode_queue.sv
// Circular fetch queue that presents up to DECODE_WIDTH fully decoded instructions per cycle.
// Define DECODE_RV32M_EN to decode the RV32M multiply/divide encodings instead of flagging them.
package magic_backend_types;
    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src_imm;
        logic       alu_src_pc;
        logic       bypass;
        logic       rd_we;
        logic       mem_en;
        logic [3:0] mem_op;
        logic       br;
        logic [2:0] br_op;
        logic       jmp;
        logic       wb_pc;
        logic       muldiv;
        logic [2:0] muldiv_op;
    } control_word_t;

    typedef struct packed {
        control_word_t ctrl;
        logic [31:0]   imm;
        logic          illegal;
    } decoded_t;
endpackage

module decode_queue
    import magic_backend_types::*;
#(
    parameter int unsigned FETCH_WIDTH  = 2,
    parameter int unsigned DECODE_WIDTH = 2,
    parameter int unsigned DEPTH        = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [FETCH_WIDTH-1:0]              in_valid,
    input  logic [FETCH_WIDTH*32-1:0]           in_instr,
    input  logic [FETCH_WIDTH*32-1:0]           in_pc,
    output logic                                in_ready,
    output logic [DECODE_WIDTH-1:0]             out_valid,
    input  logic [$clog2(DECODE_WIDTH+1)-1:0]   out_deq,
    output control_word_t [DECODE_WIDTH-1:0]    out_ctrl,
    output logic [DECODE_WIDTH*32-1:0]          out_imm,
    output logic [DECODE_WIDTH*5-1:0]           out_rs1,
    output logic [DECODE_WIDTH*5-1:0]           out_rs2,
    output logic [DECODE_WIDTH*5-1:0]           out_rd,
    output logic [DECODE_WIDTH*32-1:0]          out_pc,
    output logic [DECODE_WIDTH-1:0]             out_illegal,
    output logic [$clog2(DEPTH+1)-1:0]          occupancy
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned LANE_W = $clog2(FETCH_WIDTH + 1);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    logic [31:0]       instr_q [DEPTH];
    logic [31:0]       pc_q    [DEPTH];
    logic              push_en;
    logic [LANE_W-1:0] push_cnt;
    decoded_t          dec     [DECODE_WIDTH];

    function automatic decoded_t decode(input logic [31:0] ins);
        decoded_t   d;
        logic [2:0] f3;
        logic [6:0] f7;
        d  = '0;
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (ins[6:0])
            OpLui: begin
                d.ctrl.bypass = 1'b1;
                d.ctrl.rd_we  = 1'b1;
                d.imm         = {ins[31:12], 12'b0};
            end
            OpAuipc: begin
                d.ctrl.alu_src_pc  = 1'b1;
                d.ctrl.alu_src_imm = 1'b1;
                d.ctrl.rd_we       = 1'b1;
                d.imm              = {ins[31:12], 12'b0};
            end
            OpJal: begin
                d.ctrl.jmp   = 1'b1;
                d.ctrl.wb_pc = 1'b1;
                d.ctrl.rd_we = 1'b1;
                d.imm        = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            OpJalr: begin
                d.ctrl.jmp         = 1'b1;
                d.ctrl.wb_pc       = 1'b1;
                d.ctrl.alu_src_imm = 1'b1;
                d.ctrl.rd_we       = 1'b1;
                d.imm              = {{20{ins[31]}}, ins[31:20]};
            end
            OpBranch: begin
                d.ctrl.br    = 1'b1;
                d.ctrl.br_op = f3;
                d.imm        = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            OpLoad: begin
                d.ctrl.mem_en      = 1'b1;
                d.ctrl.mem_op      = {1'b0, f3};
                d.ctrl.alu_src_imm = 1'b1;
                d.ctrl.rd_we       = 1'b1;
                d.imm              = {{20{ins[31]}}, ins[31:20]};
            end
            OpStore: begin
                d.ctrl.mem_en      = 1'b1;
                d.ctrl.mem_op      = {1'b1, f3};
                d.ctrl.alu_src_imm = 1'b1;
                d.imm              = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            OpImm: begin
                // funct7[5] only distinguishes srli/srai; elsewhere it is immediate data
                d.ctrl.alu_op      = {(f3 == 3'd5) & f7[5], f3};
                d.ctrl.alu_src_imm = 1'b1;
                d.ctrl.rd_we       = 1'b1;
                d.imm              = {{20{ins[31]}}, ins[31:20]};
            end
            OpReg: begin
                if (f7 == 7'b0000001) begin
`ifdef DECODE_RV32M_EN
                    d.ctrl.muldiv    = 1'b1;
                    d.ctrl.muldiv_op = f3;
                    d.ctrl.rd_we     = 1'b1;
`else
                    d.illegal = 1'b1;
`endif
                end else begin
                    d.ctrl.alu_op = {f7[5], f3};
                    d.ctrl.rd_we  = 1'b1;
                end
            end
            default: d.illegal = 1'b1;
        endcase
        if (ins[11:7] == 5'd0) begin
            d.ctrl.rd_we = 1'b0;
        end
        return d;
    endfunction

    // Readiness looks only at the registered count so in_ready never depends on out_deq.
    assign in_ready  = (count_q <= CNT_W'(DEPTH - FETCH_WIDTH));
    assign push_en   = in_ready && in_valid[0] && !flush && !rst;
    assign occupancy = count_q;

    always_comb begin
        push_cnt = '0;
        if (push_en) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                push_cnt = push_cnt + LANE_W'(in_valid[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PTR_W'(out_deq);
            tail_q  <= tail_q + PTR_W'(push_cnt);
            count_q <= count_q + CNT_W'(push_cnt) - CNT_W'(out_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (in_valid[i]) begin
                    instr_q[tail_q + PTR_W'(i)] <= in_instr[i*32 +: 32];
                    pc_q[tail_q + PTR_W'(i)]    <= in_pc[i*32 +: 32];
                end
            end
        end
    end

    always_comb begin
        out_valid   = '0;
        out_ctrl    = '0;
        out_imm     = '0;
        out_rs1     = '0;
        out_rs2     = '0;
        out_rd      = '0;
        out_pc      = '0;
        out_illegal = '0;
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            dec[k]             = decode(instr_q[head_q + PTR_W'(k)]);
            out_valid[k]       = (count_q > CNT_W'(k));
            out_ctrl[k]        = dec[k].ctrl;
            out_imm[k*32 +: 32] = dec[k].imm;
            out_illegal[k]     = dec[k].illegal;
            out_rs1[k*5 +: 5]  = instr_q[head_q + PTR_W'(k)][19:15];
            out_rs2[k*5 +: 5]  = instr_q[head_q + PTR_W'(k)][24:20];
            out_rd[k*5 +: 5]   = instr_q[head_q + PTR_W'(k)][11:7];
            out_pc[k*32 +: 32] = pc_q[head_q + PTR_W'(k)];
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: reset, fill/drop, wrap ordering, push+pop, flush, decode.
// Expectations for the RV32M encoding follow DECODE_RV32M_EN.
module tb_decode_queue;
    import magic_backend_types::*;

    logic                 clk;
    logic                 rst;
    logic                 flush;
    logic [1:0]           in_valid;
    logic [63:0]          in_instr;
    logic [63:0]          in_pc;
    logic                 in_ready;
    logic [1:0]           out_valid;
    logic [1:0]           out_deq;
    control_word_t [1:0]  out_ctrl;
    logic [63:0]          out_imm;
    logic [9:0]           out_rs1;
    logic [9:0]           out_rs2;
    logic [9:0]           out_rd;
    logic [63:0]          out_pc;
    logic [1:0]           out_illegal;
    logic [3:0]           occupancy;

    int n_checks = 0;
    int n_errors = 0;

    decode_queue #(
        .FETCH_WIDTH (2),
        .DECODE_WIDTH(2),
        .DEPTH       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_deq    (out_deq),
        .out_ctrl   (out_ctrl),
        .out_imm    (out_imm),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_rd     (out_rd),
        .out_pc     (out_pc),
        .out_illegal(out_illegal),
        .occupancy  (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample #1 after the edge.
    task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [31:0] p0, input logic [31:0] p1,
                         input logic [1:0] deq, input logic fl);
        if (deq != 2'd0) begin
            check_eq("deq_legal", 32'(deq <= 2'(out_valid[0]) + 2'(out_valid[1])), 32'd1);
        end
        in_valid = v;
        in_instr = {i1, i0};
        in_pc    = {p1, p0};
        out_deq  = deq;
        flush    = fl;
        @(posedge clk);
        #1;
        in_valid = '0;
        out_deq  = '0;
        flush    = 1'b0;
    endtask

    logic [31:0] exp_pc;
    logic [31:0] nxt_pc;
    logic [1:0]  d;

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = '0;
        in_instr = '0;
        in_pc    = '0;
        out_deq  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_occ", 32'(occupancy), 32'd0);

        // addi x1,x0,5 ; nop
        drive(2'b11, 32'h0050_0093, 32'h0000_0013, 32'h1000, 32'h1004, 2'd0, 1'b0);
        check_eq("p1_valid", 32'(out_valid), 32'd3);
        check_eq("p1_occ", 32'(occupancy), 32'd2);
        check_eq("p1_imm0", out_imm[31:0], 32'd5);
        check_eq("p1_rd0", 32'(out_rd[4:0]), 32'd1);
        check_eq("p1_rs1_0", 32'(out_rs1[4:0]), 32'd0);
        check_eq("p1_we0", 32'(out_ctrl[0].rd_we), 32'd1);
        check_eq("p1_rd1", 32'(out_rd[9:5]), 32'd0);
        check_eq("p1_we1", 32'(out_ctrl[1].rd_we), 32'd0);
        check_eq("p1_pc0", out_pc[31:0], 32'h1000);
        check_eq("p1_pc1", out_pc[63:32], 32'h1004);
        check_eq("p1_ill", 32'(out_illegal), 32'd0);

        // Fill to DEPTH, then a dropped push
        for (int g = 0; g < 3; g++) begin
            drive(2'b11, 32'h13, 32'h13, 32'h1008 + 32'(8 * g), 32'h100C + 32'(8 * g),
                  2'd0, 1'b0);
        end
        check_eq("full_occ", 32'(occupancy), 32'd8);
        check_eq("full_ready", 32'(in_ready), 32'd0);
        drive(2'b11, 32'h13, 32'h13, 32'h5000, 32'h5004, 2'd0, 1'b0);
        check_eq("drop_occ", 32'(occupancy), 32'd8);
        check_eq("drop_pc0", out_pc[31:0], 32'h1000);
        check_eq("drop_pc1", out_pc[63:32], 32'h1004);

        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b1);
        check_eq("flush_occ", 32'(occupancy), 32'd0);
        check_eq("flush_valid", 32'(out_valid), 32'd0);

        // Push 2 / pop 1 until the tail wraps, then drain one per cycle
        exp_pc = 32'h2000;
        nxt_pc = 32'h2000;
        for (int i = 0; i < 6; i++) begin
            d = (i == 0) ? 2'd0 : 2'd1;
            if (i != 0) begin
                check_eq("wrap_pc0", out_pc[31:0], exp_pc);
                check_eq("wrap_pc1", out_pc[63:32], exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
            end
            drive(2'b11, 32'h13, 32'h13, nxt_pc, nxt_pc + 32'd4, d, 1'b0);
            nxt_pc = nxt_pc + 32'd8;
            check_eq("wrap_occ", 32'(occupancy), 32'(i + 2));
        end
        for (int j = 0; j < 7; j++) begin
            check_eq("drain_pc0", out_pc[31:0], exp_pc);
            if (j < 6) begin
                check_eq("drain_pc1", out_pc[63:32], exp_pc + 32'd4);
            end
            drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd1, 1'b0);
            exp_pc = exp_pc + 32'd4;
        end
        check_eq("drain_occ", 32'(occupancy), 32'd0);
        check_eq("drain_valid", 32'(out_valid), 32'd0);

        // Simultaneous push and pop at count 4, then the same with flush
        drive(2'b11, 32'h13, 32'h13, 32'h3000, 32'h3004, 2'd0, 1'b0);
        drive(2'b11, 32'h13, 32'h13, 32'h3008, 32'h300C, 2'd0, 1'b0);
        check_eq("pp_occ4", 32'(occupancy), 32'd4);
        drive(2'b11, 32'h13, 32'h13, 32'h3010, 32'h3014, 2'd2, 1'b0);
        check_eq("pp_occ", 32'(occupancy), 32'd4);
        check_eq("pp_pc0", out_pc[31:0], 32'h3008);
        drive(2'b11, 32'h13, 32'h13, 32'h3018, 32'h301C, 2'd2, 1'b1);
        check_eq("ppf_occ", 32'(occupancy), 32'd0);
        check_eq("ppf_valid", 32'(out_valid), 32'd0);
        check_eq("ppf_ready", 32'(in_ready), 32'd1);

        // beq offset -4 ; lui x1,0x80000
        drive(2'b11, 32'hFE00_0EE3, 32'h8000_00B7, 32'h4000, 32'h4004, 2'd0, 1'b0);
        check_eq("beq_imm", out_imm[31:0], 32'hFFFF_FFFC);
        check_eq("beq_br", 32'(out_ctrl[0].br), 32'd1);
        check_eq("beq_we", 32'(out_ctrl[0].rd_we), 32'd0);
        check_eq("lui_imm", out_imm[63:32], 32'h8000_0000);
        check_eq("lui_rd", 32'(out_rd[9:5]), 32'd1);
        check_eq("lui_byp", 32'(out_ctrl[1].bypass), 32'd1);

        // unknown opcode ; mul x3,x1,x2
        drive(2'b11, 32'h0000_007F, 32'h0220_81B3, 32'h4008, 32'h400C, 2'd2, 1'b0);
        check_eq("dec_occ", 32'(occupancy), 32'd2);
        check_eq("ill_flag", 32'(out_illegal[0]), 32'd1);
        check_eq("ill_we", 32'(out_ctrl[0].rd_we), 32'd0);
        check_eq("ill_mem", 32'(out_ctrl[0].mem_en), 32'd0);
        check_eq("ill_br", 32'(out_ctrl[0].br), 32'd0);
        check_eq("ill_jmp", 32'(out_ctrl[0].jmp), 32'd0);
        check_eq("mul_rd", 32'(out_rd[9:5]), 32'd3);
        check_eq("mul_rs1", 32'(out_rs1[9:5]), 32'd1);
        check_eq("mul_rs2", 32'(out_rs2[9:5]), 32'd2);
`ifdef DECODE_RV32M_EN
        check_eq("mul_md", 32'(out_ctrl[1].muldiv), 32'd1);
        check_eq("mul_mdop", 32'(out_ctrl[1].muldiv_op), 32'd0);
        check_eq("mul_ill", 32'(out_illegal[1]), 32'd0);
        check_eq("mul_we", 32'(out_ctrl[1].rd_we), 32'd1);
`else
        check_eq("mul_md", 32'(out_ctrl[1].muldiv), 32'd0);
        check_eq("mul_ill", 32'(out_illegal[1]), 32'd1);
        check_eq("mul_we", 32'(out_ctrl[1].rd_we), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
